// File: rtl/relobi_pkg.sv
// Reliable-OBI helpers: bus configuration, R-other field widths and Hsiao column generation.
package relobi_pkg;

    typedef struct packed {
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{IdWidth: 32'd1};

    function automatic int unsigned relobi_r_other_width(obi_cfg_t cfg, int unsigned opt_width = 1);
        return cfg.IdWidth + 1 + opt_width;
    endfunction

    // Smallest r with enough odd-weight (>=3) columns to cover every data bit.
    function automatic int unsigned relobi_r_other_ecc_width(obi_cfg_t cfg, int unsigned opt_width = 1);
        int unsigned k;
        int unsigned r;
        k = relobi_r_other_width(cfg, opt_width);
        r = 2;
        while (((32'd1 << (r - 1)) - r) < k) r++;
        return r;
    endfunction

    function automatic int unsigned relobi_r_other_entry_width(obi_cfg_t cfg, int unsigned opt_width);
        return relobi_r_other_width(cfg, opt_width) + relobi_r_other_ecc_width(cfg, opt_width);
    endfunction

    // Column of data bit idx: the idx-th odd-weight (>=3) value in ascending order.
    function automatic int unsigned hsiao_column(int unsigned ecc_w, int unsigned idx);
        int unsigned n;
        n = 0;
        for (int unsigned v = 0; v < (32'd1 << ecc_w); v++) begin
            if ($countones(v) >= 3 && ($countones(v) % 2) == 1) begin
                if (n == idx) return v;
                n++;
            end
        end
        return 0;
    endfunction

endpackage

// File: rtl/hsiao_ecc_dec.sv
// Hsiao SEC-DED decoder over a {ecc, data} word; reports syndrome and error class.
module hsiao_ecc_dec import relobi_pkg::*; #(
    parameter int unsigned DataWidth = 8,
    parameter int unsigned EccWidth  = 5
) (
    input  logic [EccWidth+DataWidth-1:0] in_i,
    output logic [DataWidth-1:0]          out_o,
    output logic [EccWidth-1:0]           syndrome_o,
    output logic [1:0]                    err_o
);

    logic [EccWidth-1:0] syn;

    always_comb begin
        syn = in_i[DataWidth +: EccWidth];
        for (int unsigned j = 0; j < DataWidth; j++) begin
            if (in_i[j]) syn = syn ^ EccWidth'(hsiao_column(EccWidth, j));
        end
    end

    always_comb begin
        out_o = in_i[DataWidth-1:0];
        for (int unsigned j = 0; j < DataWidth; j++) begin
            if (syn == EccWidth'(hsiao_column(EccWidth, j))) out_o[j] = ~out_o[j];
        end
    end

    // Odd-weight syndrome points at a single flip; even-weight nonzero means two or more.
    assign syndrome_o = syn;
    assign err_o[0]   = (|syn) & (^syn);
    assign err_o[1]   = (|syn) & ~(^syn);

endmodule

// File: rtl/relobi_r_other_buffer.sv
// Elastic buffer for encoded R-other beats; payload passes through unmodified.
// RELOBI_R_BUF_FAULT_CHECK_EN enables head syndrome check and the fault counter.
module relobi_r_other_buffer import relobi_pkg::*; #(
    parameter obi_cfg_t    Cfg           = ObiDefaultConfig,
    parameter type         r_optional_t  = logic,
    parameter int unsigned OtherEccWidth = relobi_r_other_ecc_width(Cfg, $bits(r_optional_t)),
    parameter int unsigned Depth         = 2,
    parameter int unsigned CntWidth      = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [Cfg.IdWidth-1:0]   rid_i,
    input  logic                     err_i,
    input  r_optional_t              r_optional_i,
    input  logic [OtherEccWidth-1:0] other_ecc_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [Cfg.IdWidth-1:0]   rid_o,
    output logic                     err_o,
    output r_optional_t              r_optional_o,
    output logic [OtherEccWidth-1:0] other_ecc_o,
    output logic                     fault_o,
    output logic                     uncorr_o,
    output logic [CntWidth-1:0]      fault_cnt_o
);

    localparam int unsigned OptWidth   = $bits(r_optional_t);
    localparam int unsigned DataWidth  = relobi_r_other_width(Cfg, OptWidth);
    localparam int unsigned EntryWidth = relobi_r_other_entry_width(Cfg, OptWidth);
    localparam int unsigned PtrWidth   = $clog2(Depth);
    localparam int unsigned CountWidth = $clog2(Depth + 1);

    logic [EntryWidth-1:0] mem [Depth];
    logic [EntryWidth-1:0] entry_in;
    logic [EntryWidth-1:0] head;
    logic [PtrWidth-1:0]   wr_ptr;
    logic [PtrWidth-1:0]   rd_ptr;
    logic [CountWidth-1:0] count;
    logic                  push;
    logic                  pop;

    assign entry_in    = {other_ecc_i, rid_i, err_i, r_optional_i};
    assign in_ready_o  = (count != CountWidth'(Depth));
    assign out_valid_o = (count != '0);
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < Depth; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= entry_in;
                wr_ptr      <= (wr_ptr == PtrWidth'(Depth - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PtrWidth'(Depth - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (push && !pop) count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    assign head = mem[rd_ptr];
    assign {other_ecc_o, rid_o, err_o, r_optional_o} = head;

`ifdef RELOBI_R_BUF_FAULT_CHECK_EN
    logic [OtherEccWidth-1:0] syndrome;
    logic [1:0]               dec_err;
    logic [DataWidth-1:0]     unused_corrected;
    logic                     unused_correctable;
    logic [CntWidth-1:0]      fault_cnt;

    hsiao_ecc_dec #(
        .DataWidth (DataWidth),
        .EccWidth  (OtherEccWidth)
    ) i_dec (
        .in_i       (head),
        .out_o      (unused_corrected),
        .syndrome_o (syndrome),
        .err_o      (dec_err)
    );

    assign unused_correctable = dec_err[0];
    assign fault_o            = out_valid_o && (|syndrome);
    assign uncorr_o           = out_valid_o && dec_err[1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fault_cnt <= '0;
        end else if (pop && fault_o && (fault_cnt != '1)) begin
            fault_cnt <= fault_cnt + 1'b1;
        end
    end

    assign fault_cnt_o = fault_cnt;
`else
    assign fault_o     = 1'b0;
    assign uncorr_o    = 1'b0;
    assign fault_cnt_o = '0;
`endif

endmodule

// File: tb/tb_relobi_r_other_buffer.sv
// Randomised bench for relobi_r_other_buffer against a queue-based model (Depth 3, CntWidth 2, 8-bit rid).
module tb_relobi_r_other_buffer;
    import relobi_pkg::*;

    localparam int unsigned DEPTH  = 3;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned ID_W   = 8;
    localparam int unsigned DATA_W = 10;
    localparam int unsigned ECC_W  = 5;
    localparam int unsigned WORD_W = 15;
    localparam obi_cfg_t    TB_CFG = '{IdWidth: ID_W};
`ifdef RELOBI_R_BUF_FAULT_CHECK_EN
    localparam bit FC = 1'b1;
`else
    localparam bit FC = 1'b0;
`endif

    typedef struct {
        logic [WORD_W-1:0] word;
        int                nflips;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WORD_W-1:0] in_word = '0;
    int                in_nflips = 0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ID_W-1:0]   rid_o;
    logic              err_o;
    logic              ropt_o;
    logic [ECC_W-1:0]  ecc_o;
    logic              fault;
    logic              uncorr;
    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] out_word;

    beat_t q[$];
    int    exp_cnt = 0;
    int    cols[DATA_W];
    int    n_cmp = 0;
    int    n_err = 0;
    bit    m_push;
    bit    m_pop;

    always #5 clk = ~clk;

    relobi_r_other_buffer #(
        .Cfg          (TB_CFG),
        .r_optional_t (logic),
        .Depth        (DEPTH),
        .CntWidth     (CNT_W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .rid_i        (in_word[9:2]),
        .err_i        (in_word[1]),
        .r_optional_i (in_word[0]),
        .other_ecc_i  (in_word[14:10]),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .rid_o        (rid_o),
        .err_o        (err_o),
        .r_optional_o (ropt_o),
        .other_ecc_o  (ecc_o),
        .fault_o      (fault),
        .uncorr_o     (uncorr),
        .fault_cnt_o  (cnt)
    );

    assign out_word = {ecc_o, rid_o, err_o, ropt_o};

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Valid codeword for {rid, err, opt}, then nflips distinct bits inverted.
    function automatic logic [WORD_W-1:0] make_word(logic [7:0] rid, logic e, logic o, int nflips, bit rid_only);
        logic [DATA_W-1:0] d;
        logic [ECC_W-1:0]  c;
        logic [WORD_W-1:0] w;
        int                p1;
        int                p2;
        int                c_bits;
        d = {rid, e, o};
        c = '0;
        for (int j = 0; j < DATA_W; j++) begin
            c_bits = cols[j];
            if (d[j]) c = c ^ c_bits[ECC_W-1:0];
        end
        w  = {c, d};
        p1 = rid_only ? int'($urandom_range(9, 2)) : int'($urandom_range(WORD_W - 1, 0));
        p2 = p1;
        while (p2 == p1) p2 = rid_only ? int'($urandom_range(9, 2)) : int'($urandom_range(WORD_W - 1, 0));
        if (nflips >= 1) w[p1] = ~w[p1];
        if (nflips == 2) w[p2] = ~w[p2];
        return w;
    endfunction

    task automatic drive(bit v, logic [WORD_W-1:0] w, int nf, bit r);
        in_valid  = v;
        in_word   = w;
        in_nflips = nf;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    // Reference model: FIFO of beats with flip counts; the head is visible the cycle after its push.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            exp_cnt = 0;
        end else begin
            m_push = in_valid && (q.size() < DEPTH);
            m_pop  = (q.size() > 0) && out_ready;
            if (m_pop) begin
                if (FC && q[0].nflips > 0 && exp_cnt < (2 ** CNT_W) - 1) exp_cnt++;
                void'(q.pop_front());
            end
            if (m_push) q.push_back('{word: in_word, nflips: in_nflips});
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", in_ready, q.size() != DEPTH);
            check("out_valid", out_valid, q.size() != 0);
            if (q.size() != 0) begin
                check("payload", out_word, q[0].word);
                check("fault", fault, FC && q[0].nflips > 0);
                check("uncorr", uncorr, FC && q[0].nflips == 2);
            end else begin
                check("fault_idle", fault, 0);
                check("uncorr_idle", uncorr, 0);
            end
            check("fault_cnt", cnt, exp_cnt);
        end
    end

    initial begin
        int n;
        int exp_sat [3] = '{3, 3, 3};
        n = 0;
        for (int v = 1; v < 32; v++) begin
            if ($countones(v) >= 3 && ($countones(v) % 2) == 1 && n < DATA_W) begin
                cols[n] = v;
                n++;
            end
        end

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_payload", out_word, 0);
        check("rst_fault", fault, 0);
        check("rst_uncorr", uncorr, 0);
        check("rst_cnt", cnt, 0);
        rst = 1'b0;

        // Hold-off with downstream stalled, then full + simultaneous pop/push.
        drive(1, make_word(8'd3, 0, 0, 0, 0), 0, 0);
        check("first_latency_valid", out_valid, 1);
        check("first_latency_rid", rid_o, 3);
        drive(1, make_word(8'd5, 0, 0, 0, 0), 0, 0);
        drive(1, make_word(8'd7, 0, 0, 0, 0), 0, 0);
        check("full_in_ready", in_ready, 0);
        drive(1, make_word(8'd9, 0, 0, 0, 0), 0, 0);
        check("held_in_ready", in_ready, 0);
        check("held_head", rid_o, 3);
        drive(1, make_word(8'd9, 0, 0, 0, 0), 0, 1);
        check("full_pop_in_ready", in_ready, 1);
        check("full_pop_head", rid_o, 5);
        drive(0, '0, 0, 1);
        check("order_head", rid_o, 7);
        drive(0, '0, 0, 1);
        check("drained", out_valid, 0);

        // Continuous streaming: each beat is at the head one cycle after its push.
        for (int i = 0; i < 100; i++) begin
            drive(1, make_word(8'(i), 1'(i), 1'(i >> 1), 0, 0), 0, 1);
            check("stream_valid", out_valid, 1);
            check("stream_rid", rid_o, 8'(i));
        end
        drive(0, '0, 0, 1);
        check("stream_drained", out_valid, 0);

        // Directed fault handling and counter saturation.
        drive(1, make_word(8'h21, 0, 1, 1, 1), 1, 0);
        check("single_fault", fault, FC);
        check("single_uncorr", uncorr, 0);
        drive(0, '0, 0, 1);
        check("single_cnt", cnt, FC ? 1 : 0);
        drive(1, make_word(8'h42, 1, 0, 2, 1), 2, 0);
        check("double_fault", fault, FC);
        check("double_uncorr", uncorr, FC);
        drive(0, '0, 0, 1);
        check("double_cnt", cnt, FC ? 2 : 0);
        for (int k = 0; k < 3; k++) begin
            drive(1, make_word(8'(k + 16), 0, 0, 1 + (k % 2), 1), 1 + (k % 2), 0);
            drive(0, '0, 0, 1);
            check("sat_cnt", cnt, FC ? exp_sat[k] : 0);
        end

        // Random traffic with 0, 1 or 2 flipped bits per beat.
        repeat (800) begin
            int nf;
            int r;
            r  = int'($urandom_range(9, 0));
            nf = (r < 7) ? 0 : ((r < 9) ? 1 : 2);
            drive($urandom_range(3, 0) != 0,
                  make_word(8'($urandom), 1'($urandom), 1'($urandom), nf, 0),
                  nf, $urandom_range(3, 0) != 0);
        end

        // Asynchronous reset with two entries held.
        repeat (DEPTH) drive(0, '0, 0, 1);
        drive(1, make_word(8'h11, 0, 0, 0, 0), 0, 0);
        drive(1, make_word(8'h22, 0, 0, 1, 0), 1, 0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_in_ready", in_ready, 1);
        check("async_rst_payload", out_word, 0);
        check("async_rst_fault", fault, 0);
        check("async_rst_cnt", cnt, 0);
        #2 rst = 1'b0;
        drive(1, make_word(8'hA5, 1, 1, 0, 0), 0, 0);
        check("post_rst_valid", out_valid, 1);
        check("post_rst_rid", rid_o, 8'hA5);
        drive(0, '0, 0, 1);
        check("post_rst_drained", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/relobi_r_other_buffer.md
# relobi_r_other_buffer

Elastic buffer for the ECC-protected "other" fields of the reliable-OBI R channel (rid, err, r_optional plus their Hsiao check bits), placed directly upstream of the R-other decoder. Encoded words pass through unmodified, so ECC stays end-to-end. The block decouples the subordinate-side R handshake from the manager side and, optionally, checks the syndrome of the head entry to report and count faults before decoding.

## Interface
- Cfg, obi_pkg::ObiDefaultConfig, bus configuration; IdWidth sets the rid width.
- r_optional_t, logic, R-channel optional payload type.
- OtherEccWidth, relobi_pkg::relobi_r_other_ecc_width(Cfg), number of check bits.
- Depth, 2, entry count; legal range 2..16.
- CntWidth, 8, width of the fault counter.
- clk_i  in  1  clock.
- rst_i  in  1  reset; **one clock, reset asynchronous and active-high**.
- in_valid_i  in  1  upstream beat valid.
- in_ready_o  out  1  buffer can accept a beat.
- rid_i / err_i / r_optional_i / other_ecc_i  in  IdWidth / 1 / $bits(r_optional_t) / OtherEccWidth  encoded upstream beat.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  downstream accepts the head.
- rid_o / err_o / r_optional_o / other_ecc_o  out  same widths  head entry, unmodified.
- fault_o  out  1  head syndrome nonzero, qualified by out_valid_o.
- uncorr_o  out  1  head error is uncorrectable (even-weight nonzero syndrome), qualified by out_valid_o.
- fault_cnt_o  out  CntWidth  saturating count of faulty beats handed off.

## Operation
- Circular buffer: write pointer, read pointer, occupancy count of $clog2(Depth+1) bits. Pointers wrap from Depth-1 to 0 (Depth need not be a power of two).
- Push when in_valid_i && in_ready_o. Pop when out_valid_o && out_ready_i. Both may happen in the same cycle: count is unchanged and both pointers advance.
- in_ready_o = (count != Depth), driven from registered state only. There is no combinational path from out_ready_i to in_ready_o. When the buffer is full, a same-cycle pop does not enable a push.
- out_valid_o = (count != 0). Outputs show the entry at the read pointer. There is no fall-through.
- The payload holds stable while out_valid_o && !out_ready_i.
- Fault check: Hsiao syndrome over {other_ecc, rid, err, r_optional} of the head entry.
  - fault_o = syndrome != 0.
  - uncorr_o = fault_o and the syndrome has even weight.
  - Both are 0 whenever out_valid_o = 0.
- fault_cnt_o increments by 1 on each pop with fault_o = 1 and saturates at 2^CntWidth-1.
- The buffer never corrects data. Correction stays with the downstream decoder.

## Timing
- Latency from push to out_valid_o is 1 cycle.
- Throughput is 1 beat per cycle while neither side stalls.
- Reset values: in_ready_o = 1, out_valid_o = 0, and all payload outputs = 0 (storage is reset to 0). fault_o = 0, uncorr_o = 0, fault_cnt_o = 0.
- Reset asserted mid-transfer drops all entries immediately (asynchronous). Pointers and count return to 0. Beats in flight are lost and upstream must re-issue them.
- A push into an empty buffer that coincides with out_ready_i = 1 is not popped that cycle.

## Configuration
- RELOBI_R_BUF_FAULT_CHECK_EN defined:
  - the syndrome logic is instantiated;
  - fault_o, uncorr_o and fault_cnt_o behave as specified above.
- Macro undefined:
  - no syndrome logic is built;
  - fault_o, uncorr_o and fault_cnt_o are tied to 0;
  - buffering behaviour is identical.

## Structure
- relobi_pkg holds:
  - relobi_r_other_width / relobi_r_other_ecc_width (already present);
  - a new helper, relobi_r_other_entry_width(Cfg, r_optional_t-width) = other width + ecc width.
- The entry is stored as one packed vector of that width. No new types go in the package.
- Sub-module: one hsiao_ecc_dec instance on the head entry, used only for its syndrome_o/err_o outputs. Its corrected output is left unconnected. The instance exists only under RELOBI_R_BUF_FAULT_CHECK_EN.

## Test plan
- Depth = 2, out_ready_i = 0, push rid = 3 then rid = 5:
  - in_ready_o falls after the second push;
  - a third beat is held off;
  - releasing out_ready_i yields 3 then 5 in order.
- Continuous streaming (both sides ready, 100 beats with rid incrementing): one beat per cycle, 1-cycle latency, no loss or reorder. Also check pointer wrap with Depth = 3.
- Full buffer, out_ready_i = 1 and in_valid_i = 1 in the same cycle: the pop occurs, the push is refused (in_ready_o = 0), and count drops to Depth-1.
- Single bit flipped in the rid of a pushed beat (macro defined): fault_o = 1, uncorr_o = 0, fault_cnt_o = 1 after the pop, and the payload comes out unmodified.
- Two bits flipped: fault_o = 1, uncorr_o = 1. With CntWidth = 2, four faulty pops leave fault_cnt_o saturated at 3.
- Reset asserted with 2 entries held: outputs return to their reset values without a clock edge, and after reset the first new beat is delivered correctly. With the macro undefined, all fault outputs stay 0 throughout.
